// File: rtl/marquee_scroller_if.sv
`default_nettype none
// ============================================================================
//  Module   : marquee_scroller_if
//  Brief    : Control, message-load and window-output bundle of the marquee
//             scroller. The master side (tick source / message loader) drives
//             the controls; the slave side (the scroller) returns the window.
//  Revision : 1.0 - initial release
// ============================================================================
interface marquee_scroller_if #(
    parameter int SYM_W = 5,
    parameter int DEPTH = 16,
    parameter int WIN   = 4
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic                   tick;
    logic                   run;
    logic                   dir;
    logic                   wr_en;
    logic [PTR_W-1:0]       wr_addr;
    logic [SYM_W-1:0]       wr_data;
    logic                   len_we;
    logic [LEN_W-1:0]       len_data;
    logic [WIN*SYM_W-1:0]   win_o;
    logic [PTR_W-1:0]       ptr_o;
    logic                   wrap_o;

    modport master (
        output tick, run, dir, wr_en, wr_addr, wr_data, len_we, len_data,
        input  win_o, ptr_o, wrap_o
    );

    modport slave (
        input  tick, run, dir, wr_en, wr_addr, wr_data, len_we, len_data,
        output win_o, ptr_o, wrap_o
    );
endinterface
`default_nettype wire

// File: rtl/marquee_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : marquee_scroller
//  Brief    : Loadable circular marquee. Holds up to DEPTH symbols and shows a
//             WIN-digit sliding window that scrolls one step per tick,
//             left or right, with runtime message length and wrap pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module marquee_scroller #(
    parameter int SYM_W = 5,
    parameter int DEPTH = 16,
    parameter int WIN   = 4,
    parameter int BLANK = 15
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    marquee_scroller_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);

    localparam logic [LEN_W-1:0] c_DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [PTR_W:0]   c_DEPTH_ADR = (PTR_W + 1)'(DEPTH);
    localparam logic [SYM_W-1:0] c_BLANK     = SYM_W'(BLANK);

    logic [SYM_W-1:0]     r_mem [DEPTH];
    logic [LEN_W-1:0]     r_len;
    logic [PTR_W-1:0]     r_ptr;
    logic                 r_wrap;
    logic [WIN*SYM_W-1:0] r_win;

    logic                 w_wr_ok;
    logic                 w_len_acc;
    logic [LEN_W-1:0]     w_len_new;
    logic [PTR_W-1:0]     w_len_m1;
    logic                 w_step;
    logic                 w_at_end;
    logic                 w_at_zero;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic                 w_wrap_nxt;
    logic [PTR_W-1:0]     w_idx [WIN];

    // Out-of-range addresses are dropped; a zero length is not a valid message.
    assign w_wr_ok   = bus.wr_en && ({1'b0, bus.wr_addr} < c_DEPTH_ADR);
    assign w_len_acc = bus.len_we && (bus.len_data != '0);
    assign w_len_new = (bus.len_data > c_DEPTH_LEN) ? c_DEPTH_LEN : bus.len_data;
    assign w_len_m1  = PTR_W'(r_len - 1'b1);
    assign w_step    = bus.tick && bus.run && !w_len_acc;
    assign w_at_end  = (r_ptr == w_len_m1);
    assign w_at_zero = (r_ptr == '0);

    // Next start pointer and wrap flag for a qualifying scroll step.
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_wrap_nxt = 1'b0;
        if (bus.dir) begin
            w_ptr_nxt  = w_at_zero ? w_len_m1 : r_ptr - 1'b1;
            w_wrap_nxt = w_at_zero;
        end else begin
            w_ptr_nxt  = w_at_end ? '0 : r_ptr + 1'b1;
            w_wrap_nxt = w_at_end;
        end
    end

    // Digit addresses: each digit is the previous one plus one, folded at len-1.
    // Incremental folding keeps the modulo exact even when len < WIN.
    always_comb begin
        w_idx[0] = r_ptr;
        for (int k = 1; k < WIN; k++) begin
            w_idx[k] = (w_idx[k-1] == w_len_m1) ? '0 : w_idx[k-1] + 1'b1;
        end
    end

    // Message buffer: cleared to blanks on reset, written one symbol at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= c_BLANK;
            end
        end else if (w_wr_ok) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Length, start pointer and wrap pulse; a length load restarts the message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= c_DEPTH_LEN;
            r_ptr  <= '0;
            r_wrap <= 1'b0;
        end else if (w_len_acc) begin
            r_len  <= w_len_new;
            r_ptr  <= '0;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_ptr  <= w_ptr_nxt;
            r_wrap <= w_wrap_nxt;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Window register refreshed every cycle from the current pointer and buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= {WIN{c_BLANK}};
        end else begin
            for (int k = 0; k < WIN; k++) begin
                r_win[k*SYM_W +: SYM_W] <= r_mem[w_idx[k]];
            end
        end
    end

    assign bus.win_o  = r_win;
    assign bus.ptr_o  = r_ptr;
    assign bus.wrap_o = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_marquee_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_marquee_scroller
//  Brief    : Directed bench for marquee_scroller. Stimulus pushes expected
//             window/pointer/wrap values into a queue tagged with the cycle
//             they apply to; a monitor pops and compares mid-cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_marquee_scroller;
    localparam int SYM_W = 5;
    localparam int DEPTH = 16;
    localparam int WIN   = 4;
    localparam int BLANK = 15;
    localparam int WW    = WIN * SYM_W;

    typedef struct {
        string          name;
        logic [WW-1:0]  win;
        int             ptr;
        bit             wrap;
        int             cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_bad;
    exp_t q[$];

    marquee_scroller_if #(.SYM_W(SYM_W), .DEPTH(DEPTH), .WIN(WIN)) bus ();

    marquee_scroller #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH),
        .WIN   (WIN),
        .BLANK (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WW-1:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {SYM_W'(d3), SYM_W'(d2), SYM_W'(d1), SYM_W'(d0)};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input string name, input logic [WW-1:0] win, input int ptr, input bit wrap);
        exp_t e;
        e.name = name;
        e.win  = win;
        e.ptr  = ptr;
        e.wrap = wrap;
        e.cyc  = cyc;
        q.push_back(e);
    endtask

    // Monitor: compare every expectation due in this cycle, mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec = n_vec + 1;
            if (bus.win_o !== e.win || int'(bus.ptr_o) != e.ptr || bus.wrap_o !== e.wrap) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got win=%h ptr=%0d wrap=%b, want win=%h ptr=%0d wrap=%b",
                         e.name, bus.win_o, bus.ptr_o, bus.wrap_o, e.win, e.ptr, e.wrap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int msg [13] = '{3, 6, 13, 0, 7, 15, 8, 9, 12, 14, 2, 1, 11};
        logic [WW-1:0] blank4;
        blank4 = pk(BLANK, BLANK, BLANK, BLANK);
        cyc   = 0;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.tick = 1'b0; bus.run = 1'b0; bus.dir = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.len_we = 1'b0; bus.len_data = '0;

        // Reset and idle behaviour
        step(2);
        expect_now("rst_hold", blank4, 0, 0);
        rst_n = 1'b1;
        step();
        expect_now("reset", blank4, 0, 0);
        bus.tick = 1'b1;
        step(3);
        bus.tick = 1'b0;
        step();
        expect_now("tick_run0", blank4, 0, 0);

        // Load the 13-symbol message and its length
        for (int i = 0; i < 13; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = 5'(msg[i]);
            step();
        end
        bus.wr_en = 1'b0;
        bus.len_we = 1'b1; bus.len_data = 5'd13;
        step();
        bus.len_we = 1'b0;
        step();
        expect_now("loaded", pk(3, 6, 13, 0), 0, 0);

        // Left scrolling
        bus.run = 1'b1; bus.dir = 1'b0;
        bus.tick = 1'b1; step(); bus.tick = 1'b0; step();
        expect_now("left1", pk(6, 13, 0, 7), 1, 0);
        bus.tick = 1'b1; step(11); bus.tick = 1'b0; step();
        expect_now("left12", pk(11, 3, 6, 13), 12, 0);
        bus.tick = 1'b1; step(); bus.tick = 1'b0;
        expect_now("wrap_left", pk(11, 3, 6, 13), 0, 1);
        step();
        expect_now("after_wrap_left", pk(3, 6, 13, 0), 0, 0);

        // Right scrolling from ptr 0
        bus.dir = 1'b1;
        bus.tick = 1'b1; step(); bus.tick = 1'b0;
        expect_now("wrap_right", pk(3, 6, 13, 0), 12, 1);
        step();
        expect_now("after_wrap_right", pk(11, 3, 6, 13), 12, 0);
        bus.tick = 1'b1; step(); bus.tick = 1'b0; step();
        expect_now("right2", pk(1, 11, 3, 6), 11, 0);

        // Short message, ignored zero length, clamped oversize length
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 5'd5; step();
        bus.wr_addr = 4'd1; bus.wr_data = 5'd9; step();
        bus.wr_en = 1'b0;
        bus.len_we = 1'b1; bus.len_data = 5'd2; step();
        bus.len_we = 1'b0; step();
        expect_now("short", pk(5, 9, 5, 9), 0, 0);
        bus.dir = 1'b0;
        bus.tick = 1'b1; step(); bus.tick = 1'b0; step();
        expect_now("short_tick", pk(9, 5, 9, 5), 1, 0);
        bus.len_we = 1'b1; bus.len_data = 5'd0; step();
        bus.len_we = 1'b0; step();
        expect_now("len_zero_ignored", pk(9, 5, 9, 5), 1, 0);
        bus.len_we = 1'b1; bus.len_data = 5'd20; step();
        bus.len_we = 1'b0; step();
        expect_now("len_clamped", pk(5, 9, 13, 0), 0, 0);
        bus.dir = 1'b1;
        bus.tick = 1'b1; step(); bus.tick = 1'b0;
        expect_now("len16_wrap", pk(5, 9, 13, 0), 15, 1);
        step();
        expect_now("len16_window", pk(15, 5, 9, 13), 15, 0);

        // Length write coinciding with a tick
        bus.dir = 1'b0;
        bus.len_we = 1'b1; bus.len_data = 5'd13; step();
        bus.len_we = 1'b0;
        bus.tick = 1'b1; step(4); bus.tick = 1'b0;
        bus.len_we = 1'b1; bus.len_data = 5'd6; bus.tick = 1'b1;
        step();
        bus.len_we = 1'b0; bus.tick = 1'b0;
        expect_now("len_with_tick", pk(7, 15, 8, 9), 0, 0);
        step();
        expect_now("len6_window", pk(5, 9, 13, 0), 0, 0);

        // Symbol write to mem[ptr+1] coinciding with a tick
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 5'd20; bus.tick = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.tick = 1'b0;
        expect_now("wr_tick_edge", pk(5, 9, 13, 0), 1, 0);
        step();
        expect_now("wr_tick_window", pk(20, 13, 0, 7), 1, 0);

        // Asynchronous reset between clock edges while scrolling
        bus.tick = 1'b1;
        step(2);
        #1;
        rst_n = 1'b0;
        expect_now("async_reset", blank4, 0, 0);
        bus.tick = 1'b0;
        step();
        rst_n = 1'b1;
        step(2);
        expect_now("post_reset", blank4, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            n_bad = n_bad + q.size();
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
